// File: rtl/mips_wb_pkg.sv
// Shared widths and the pending-write entry type for the MIPS writeback queue.
//   REG_W     : register address width
//   DATA_W    : register data width
//   DEPTH_DEF : default number of pending-write entries
//   COUNT_W   : width of the pending_count output (holds 0..16)
package mips_wb_pkg;

   localparam int unsigned REG_W     = 5;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned DEPTH_DEF = 4;
   localparam int unsigned COUNT_W   = 5;

   typedef struct packed {
      logic              valid;
      logic [REG_W-1:0]  wreg;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/mips_wb_fifo.sv
// Circular storage for pending register writes.
//   clk, rst_n           : clock, async active-low reset
//   push, push_reg/data  : enqueue one entry at the write pointer
//   pop                  : retire the entry at the read pointer
//   entries_o            : all slots (valid bit marks live entries)
//   rd_ptr_o             : index of the oldest entry
//   count_o              : number of live entries
module mips_wb_fifo
   import mips_wb_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [REG_W-1:0]             push_reg,
   input  logic [DATA_W-1:0]            push_data,
   input  logic                         pop,
   output wb_entry_t [DEPTH-1:0]        entries_o,
   output logic [$clog2(DEPTH)-1:0]     rd_ptr_o,
   output logic [COUNT_W-1:0]           count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   wb_entry_t          mem_q [DEPTH];
   wb_entry_t          mem_d [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [COUNT_W-1:0] count_q, count_d;

   // Next-state: pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (pop) begin
         mem_d[rd_ptr_q].valid = 1'b0;
         rd_ptr_d              = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
         mem_d[wr_ptr_q] = '{valid: 1'b1, wreg: push_reg, data: push_data};
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      count_d = count_q + COUNT_W'(push) - COUNT_W'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         entries_o[i] = mem_q[i];
      end
   end

   assign rd_ptr_o = rd_ptr_q;
   assign count_o  = count_q;

endmodule

// File: rtl/mips_writeback_queue.sv
// Writeback queue between ALU / load unit and the register file.
//   alu_*/mem_*        : result offers (valid/ready); load unit has priority
//   signal_reg_write,
//   write_reg/data     : head entry, committed and retired every edge it is shown
//   lookup_reg_k       : operand addresses; lookup_hit_k/data_k report the
//                        youngest pending write to that register
//   pending_count      : live entry count
module mips_writeback_queue
   import mips_wb_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               alu_valid,
   input  logic [REG_W-1:0]   alu_reg,
   input  logic [DATA_W-1:0]  alu_data,
   output logic               alu_ready,
   input  logic               mem_valid,
   input  logic [REG_W-1:0]   mem_reg,
   input  logic [DATA_W-1:0]  mem_data,
   output logic               mem_ready,
   output logic               signal_reg_write,
   output logic [REG_W-1:0]   write_reg,
   output logic [DATA_W-1:0]  write_data,
   input  logic [REG_W-1:0]   lookup_reg_1,
   input  logic [REG_W-1:0]   lookup_reg_2,
   output logic               lookup_hit_1,
   output logic               lookup_hit_2,
   output logic [DATA_W-1:0]  lookup_data_1,
   output logic [DATA_W-1:0]  lookup_data_2,
   output logic [COUNT_W-1:0] pending_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   wb_entry_t [DEPTH-1:0] entries;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  full_c;
   logic                  mem_fire_c;
   logic                  alu_fire_c;
   logic                  push_c;
   logic                  pop_c;
   logic [REG_W-1:0]      push_reg_c;
   logic [DATA_W-1:0]     push_data_c;
   logic [PTR_W-1:0]      idx_c;

   // Arbitration: no refill while full, even if the head retires this edge.
   assign full_c     = (pending_count == COUNT_W'(DEPTH));
   assign mem_ready  = !full_c;
   assign alu_ready  = !full_c && !mem_valid;
   assign mem_fire_c = mem_valid && mem_ready;
   assign alu_fire_c = alu_valid && alu_ready;

   // Writes to r0 are accepted and dropped.
   assign push_reg_c  = mem_fire_c ? mem_reg  : alu_reg;
   assign push_data_c = mem_fire_c ? mem_data : alu_data;
   assign push_c      = (mem_fire_c && (mem_reg != '0)) || (alu_fire_c && (alu_reg != '0));
   assign pop_c       = (pending_count != '0);

   mips_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_c),
      .push_reg  (push_reg_c),
      .push_data (push_data_c),
      .pop       (pop_c),
      .entries_o (entries),
      .rd_ptr_o  (rd_ptr),
      .count_o   (pending_count)
   );

   // Register-file port shows the head while anything is pending.
   assign signal_reg_write = pop_c;
   assign write_reg        = pop_c ? entries[rd_ptr].wreg : '0;
   assign write_data       = pop_c ? entries[rd_ptr].data : '0;

   // Walk oldest to youngest so the last match is the youngest.
   always_comb begin
      lookup_hit_1  = 1'b0;
      lookup_hit_2  = 1'b0;
      lookup_data_1 = '0;
      lookup_data_2 = '0;
      idx_c         = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx_c = rd_ptr + PTR_W'(k);
         if (entries[idx_c].valid && (lookup_reg_1 != '0) && (entries[idx_c].wreg == lookup_reg_1)) begin
            lookup_hit_1  = 1'b1;
            lookup_data_1 = entries[idx_c].data;
         end
         if (entries[idx_c].valid && (lookup_reg_2 != '0) && (entries[idx_c].wreg == lookup_reg_2)) begin
            lookup_hit_2  = 1'b1;
            lookup_data_2 = entries[idx_c].data;
         end
      end
   end

endmodule

// File: tb/tb_mips_writeback_queue.sv
// Self-checking bench for mips_writeback_queue against a queue-based model.
module tb_mips_writeback_queue;

   localparam int unsigned DEPTH = 4;

   logic        clk;
   logic        rst_n;
   logic        alu_valid;
   logic [4:0]  alu_reg;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        mem_valid;
   logic [4:0]  mem_reg;
   logic [31:0] mem_data;
   logic        mem_ready;
   logic        signal_reg_write;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic [4:0]  lookup_reg_1;
   logic [4:0]  lookup_reg_2;
   logic        lookup_hit_1;
   logic        lookup_hit_2;
   logic [31:0] lookup_data_1;
   logic [31:0] lookup_data_2;
   logic [4:0]  pending_count;

   int errors = 0;
   int checks = 0;

   mips_writeback_queue #(.DEPTH(DEPTH)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .alu_valid        (alu_valid),
      .alu_reg          (alu_reg),
      .alu_data         (alu_data),
      .alu_ready        (alu_ready),
      .mem_valid        (mem_valid),
      .mem_reg          (mem_reg),
      .mem_data         (mem_data),
      .mem_ready        (mem_ready),
      .signal_reg_write (signal_reg_write),
      .write_reg        (write_reg),
      .write_data       (write_data),
      .lookup_reg_1     (lookup_reg_1),
      .lookup_reg_2     (lookup_reg_2),
      .lookup_hit_1     (lookup_hit_1),
      .lookup_hit_2     (lookup_hit_2),
      .lookup_data_1    (lookup_data_1),
      .lookup_data_2    (lookup_data_2),
      .pending_count    (pending_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: list of pending writes, oldest first.
   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;
   ent_t mq[$];

   logic        e_mrdy, e_ardy, e_we, e_hit1, e_hit2;
   logic [4:0]  e_wreg, e_cnt;
   logic [31:0] e_wdata, e_d1, e_d2;

   task automatic calc_exp();
      e_cnt   = 5'(mq.size());
      e_mrdy  = (mq.size() != DEPTH);
      e_ardy  = e_mrdy && !mem_valid;
      e_we    = (mq.size() > 0);
      e_wreg  = e_we ? mq[0].r : 5'd0;
      e_wdata = e_we ? mq[0].d : 32'd0;
      e_hit1 = 1'b0; e_d1 = '0; e_hit2 = 1'b0; e_d2 = '0;
      for (int i = 0; i < mq.size(); i++) begin
         if (lookup_reg_1 != 0 && mq[i].r == lookup_reg_1) begin e_hit1 = 1'b1; e_d1 = mq[i].d; end
         if (lookup_reg_2 != 0 && mq[i].r == lookup_reg_2) begin e_hit2 = 1'b1; e_d2 = mq[i].d; end
      end
   endtask

   // Apply one rising edge to the model using the inputs currently driven.
   task automatic model_edge();
      bit   mr, ar;
      ent_t e;
      mr = (mq.size() != DEPTH);
      ar = mr && !mem_valid;
      if (mq.size() > 0) void'(mq.pop_front());
      if (mem_valid && mr) begin
         e.r = mem_reg; e.d = mem_data;
         if (mem_reg != 0) mq.push_back(e);
      end else if (alu_valid && ar) begin
         e.r = alu_reg; e.d = alu_data;
         if (alu_reg != 0) mq.push_back(e);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 0; alu_reg = 0; alu_data = 0;
      mem_valid = 0; mem_reg = 0; mem_data = 0;
      lookup_reg_1 = 0; lookup_reg_2 = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      lookup_reg_1 = 5'd7; lookup_reg_2 = 5'd9;
      #2;
      checks++; if (pending_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", pending_count); end
      checks++; if (signal_reg_write !== 1'b0) begin errors++; $display("FAIL reset_strobe got=%0b exp=0", signal_reg_write); end
      checks++; if (write_reg !== 5'd0 || write_data !== 32'd0) begin errors++; $display("FAIL reset_wport got=%0d/%0h exp=0/0", write_reg, write_data); end
      checks++; if (lookup_hit_1 !== 1'b0 || lookup_hit_2 !== 1'b0 || lookup_data_1 !== 32'd0 || lookup_data_2 !== 32'd0) begin
         errors++; $display("FAIL reset_lookup got=%0b%0b %0h %0h exp=00 0 0", lookup_hit_1, lookup_hit_2, lookup_data_1, lookup_data_2); end
      checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b%0b exp=11", mem_ready, alu_ready); end
      mem_valid = 1'b1;
      #1;
      checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready_memvalid got=%0b exp=0", alu_ready); end
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      mq.delete();
      cycle();
   endtask

   task automatic test_basic();
      mem_valid = 1; mem_reg = 5'd8; mem_data = 32'h0000_00AA;
      @(negedge clk);
      checks++; if (mem_ready !== 1'b1 || signal_reg_write !== 1'b0) begin errors++; $display("FAIL basic_pre got rdy=%0b we=%0b exp rdy=1 we=0", mem_ready, signal_reg_write); end
      cycle();
      idle_inputs();
      @(negedge clk);
      checks++; if (signal_reg_write !== 1'b1 || write_reg !== 5'd8 || write_data !== 32'hAA) begin
         errors++; $display("FAIL basic_write got we=%0b reg=%0d data=%0h exp we=1 reg=8 data=aa", signal_reg_write, write_reg, write_data); end
      checks++; if (pending_count !== 5'd1) begin errors++; $display("FAIL basic_count1 got=%0d exp=1", pending_count); end
      cycle();
      @(negedge clk);
      checks++; if (pending_count !== 5'd0 || signal_reg_write !== 1'b0) begin errors++; $display("FAIL basic_drain got cnt=%0d we=%0b exp 0/0", pending_count, signal_reg_write); end
   endtask

   task automatic test_priority();
      alu_valid = 1; alu_reg = 5'd3; alu_data = 32'h33;
      mem_valid = 1; mem_reg = 5'd4; mem_data = 32'h44;
      @(negedge clk);
      checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin errors++; $display("FAIL prio_ready got alu=%0b mem=%0b exp alu=0 mem=1", alu_ready, mem_ready); end
      cycle();
      mem_valid = 0;
      @(negedge clk);
      checks++; if (write_reg !== 5'd4 || write_data !== 32'h44) begin errors++; $display("FAIL prio_first got %0d/%0h exp 4/44", write_reg, write_data); end
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL prio_alu_ready got=%0b exp=1", alu_ready); end
      cycle();
      idle_inputs();
      @(negedge clk);
      checks++; if (signal_reg_write !== 1'b1 || write_reg !== 5'd3 || write_data !== 32'h33) begin
         errors++; $display("FAIL prio_second got we=%0b %0d/%0h exp 1 3/33", signal_reg_write, write_reg, write_data); end
      cycle();
   endtask

   task automatic test_youngest();
      mem_valid = 1; mem_reg = 5'd5; mem_data = 32'h11;
      lookup_reg_1 = 5'd5; lookup_reg_2 = 5'd0;
      cycle();
      mem_data = 32'h22;
      @(negedge clk);
      calc_exp();
      checks++; if (lookup_hit_1 !== e_hit1 || lookup_data_1 !== e_d1) begin errors++; $display("FAIL young_first got %0b/%0h exp %0b/%0h", lookup_hit_1, lookup_data_1, e_hit1, e_d1); end
      cycle();
      mem_valid = 0;
      @(negedge clk);
      calc_exp();
      checks++; if (lookup_hit_1 !== 1'b1 || lookup_data_1 !== 32'h22) begin errors++; $display("FAIL young_second got %0b/%0h exp 1/22", lookup_hit_1, lookup_data_1); end
      checks++; if (lookup_hit_2 !== 1'b0 || lookup_data_2 !== 32'd0) begin errors++; $display("FAIL young_r0 got %0b/%0h exp 0/0", lookup_hit_2, lookup_data_2); end
      checks++; if (write_data !== e_wdata) begin errors++; $display("FAIL young_order got %0h exp %0h", write_data, e_wdata); end
      cycle();
      idle_inputs();
   endtask

   task automatic test_reg_zero();
      alu_valid = 1; alu_reg = 5'd0; alu_data = 32'hFFFF_FFFF;
      @(negedge clk);
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got=%0b exp=1", alu_ready); end
      cycle();
      alu_valid = 0;
      @(negedge clk);
      checks++; if (pending_count !== 5'd0 || signal_reg_write !== 1'b0) begin errors++; $display("FAIL r0_drop got cnt=%0d we=%0b exp 0/0", pending_count, signal_reg_write); end
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      for (int n = 0; n < 300; n++) begin
         mem_valid = ($urandom_range(0, 99) < 40);
         alu_valid = ($urandom_range(0, 99) < 70);
         mem_reg   = 5'($urandom_range(0, 31));
         alu_reg   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         mem_data  = $urandom;
         alu_data  = $urandom;
         lookup_reg_1 = (mq.size() > 0) ? mq[mq.size()-1].r : 5'($urandom_range(0, 31));
         lookup_reg_2 = 5'($urandom_range(0, 7));
         @(negedge clk);
         calc_exp();
         checks++;
         if (mem_ready !== e_mrdy || alu_ready !== e_ardy || signal_reg_write !== e_we || write_reg !== e_wreg ||
             write_data !== e_wdata || pending_count !== e_cnt || lookup_hit_1 !== e_hit1 || lookup_data_1 !== e_d1 ||
             lookup_hit_2 !== e_hit2 || lookup_data_2 !== e_d2) begin
            errors++;
            bad++;
            if (bad < 5)
               $display("FAIL random_cycle%0d got rdy=%0b%0b we=%0b wr=%0d/%0h cnt=%0d l1=%0b/%0h l2=%0b/%0h exp rdy=%0b%0b we=%0b wr=%0d/%0h cnt=%0d l1=%0b/%0h l2=%0b/%0h",
                        n, mem_ready, alu_ready, signal_reg_write, write_reg, write_data, pending_count,
                        lookup_hit_1, lookup_data_1, lookup_hit_2, lookup_data_2,
                        e_mrdy, e_ardy, e_we, e_wreg, e_wdata, e_cnt, e_hit1, e_d1, e_hit2, e_d2);
         end
         checks++; if (pending_count > 5'(DEPTH)) begin errors++; $display("FAIL random_bound got=%0d exp<=%0d", pending_count, DEPTH); end
         cycle();
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      mem_valid = 1; mem_reg = 5'd9; mem_data = 32'h99;
      cycle();
      mem_reg = 5'd10; mem_data = 32'hA0;
      lookup_reg_1 = 5'd9;
      #2;
      checks++; if (signal_reg_write !== 1'b1) begin errors++; $display("FAIL mid_pending got we=%0b exp=1", signal_reg_write); end
      rst_n = 1'b0;
      #1;
      checks++; if (signal_reg_write !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0 || pending_count !== 5'd0) begin
         errors++; $display("FAIL mid_clear got we=%0b %0d/%0h cnt=%0d exp 0 0/0 0", signal_reg_write, write_reg, write_data, pending_count); end
      checks++; if (lookup_hit_1 !== 1'b0 || lookup_data_1 !== 32'd0) begin errors++; $display("FAIL mid_lookup got %0b/%0h exp 0/0", lookup_hit_1, lookup_data_1); end
      mq.delete();
      idle_inputs();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 3; n++) begin
         cycle();
         @(negedge clk);
         checks++; if (signal_reg_write !== 1'b0 || pending_count !== 5'd0) begin errors++; $display("FAIL mid_after%0d got we=%0b cnt=%0d exp 0/0", n, signal_reg_write, pending_count); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_priority();
      test_youngest();
      test_reg_zero();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
